// File: rtl/mdu_pkg.sv
// ---------------------------------------------------------------------------
// mdu_pkg: shared opcodes, FSM encoding and constants for mul_div_unit.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mdu_pkg;

   localparam logic [1:0] OP_MULT  = 2'd0;
   localparam logic [1:0] OP_MULTU = 2'd1;
   localparam logic [1:0] OP_DIV   = 2'd2;
   localparam logic [1:0] OP_DIVU  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2
   } mdu_state_e;

   localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/mdu_abs.sv
// ---------------------------------------------------------------------------
// mdu_abs: combinational conditional two's-complement negate.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mdu_abs #(
   parameter int W = 32
) (
   input  logic [W-1:0] x,
   input  logic         neg,
   output logic [W-1:0] y
);

   always_comb begin
      y = neg ? (~x + W'(1)) : x;
   end

endmodule

`default_nettype wire

// File: rtl/mul_div_unit.sv
// ---------------------------------------------------------------------------
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO registers.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mul_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             mthi,
   input  logic             mtlo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   mdu_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   opnd_q, opnd_d;
   logic               is_div_q, is_div_d;
   logic               neg_quo_q, neg_quo_d;
   logic               neg_rem_q, neg_rem_d;
   logic               div0_q, div0_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               done_q, done_d;

   logic               op_is_mul;
   logic               op_signed;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_sh;
   logic               rem_ge;
   logic [WIDTH-1:0]   rem_sub;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign op_is_mul = (op == OP_MULT) || (op == OP_MULTU);
   assign op_signed = (op == OP_MULT) || (op == OP_DIV);

   mdu_abs #(.W(WIDTH))   u_abs_a   (.x(a), .neg(op_signed & a[WIDTH-1]), .y(a_mag));
   mdu_abs #(.W(WIDTH))   u_abs_b   (.x(b), .neg(op_signed & b[WIDTH-1]), .y(b_mag));
   mdu_abs #(.W(2*WIDTH)) u_fix_prd (.x(acc_q), .neg(neg_quo_q), .y(prod_fix));
   mdu_abs #(.W(WIDTH))   u_fix_quo (.x(acc_q[WIDTH-1:0]), .neg(neg_quo_q), .y(quo_fix));
   mdu_abs #(.W(WIDTH))   u_fix_rem (.x(acc_q[2*WIDTH-1:WIDTH]), .neg(neg_rem_q), .y(rem_fix));

   // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
   assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

   // Divide: acc = {remainder, dividend/quotient bits}, shifted left.
   assign rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
   assign rem_ge  = rem_sh >= {1'b0, opnd_q};
   assign rem_sub = rem_sh[WIDTH-1:0] - opnd_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      is_div_d  = is_div_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      div0_d    = div0_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d   = ST_CALC;
               cnt_d     = '0;
               is_div_d  = !op_is_mul;
               opnd_d    = op_is_mul ? a_mag : b_mag;
               acc_d     = {{WIDTH{1'b0}}, (op_is_mul ? b_mag : a_mag)};
               neg_quo_d = op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
               neg_rem_d = op_signed & !op_is_mul & a[WIDTH-1];
               div0_d    = !op_is_mul && (b == '0);
            end else begin
               if (mthi) hi_d = wdata;
               if (mtlo) lo_d = wdata;
            end
         end
         ST_CALC: begin
            if (is_div_q)
               acc_d = {(rem_ge ? rem_sub : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};
            else
               acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH-1)) begin
               cnt_d   = '0;
               state_d = ST_FIX;
            end
         end
         ST_FIX: begin
            if (is_div_q) begin
               hi_d = rem_fix;
               lo_d = div0_q ? WIDTH'(DIV0_LO) : quo_fix;
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         is_div_q  <= 1'b0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         div0_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         is_div_q  <= is_div_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         div0_q    <= div0_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

`default_nettype wire
